// File: rtl/alu_pkg.sv
// Shared ALU opcodes and sequencer state encoding.
// Used by the ALU and by the serial frame sequencer.
package alu_pkg;

  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] SUB = 6'h22;
  localparam logic [5:0] AND = 6'h24;
  localparam logic [5:0] OR  = 6'h25;
  localparam logic [5:0] XOR = 6'h26;
  localparam logic [5:0] SRA = 6'h03;
  localparam logic [5:0] SRL = 6'h02;
  localparam logic [5:0] NOR = 6'h27;

  typedef enum logic [2:0] {
    WAIT_OP1 = 3'd0,
    WAIT_OP2 = 3'd1,
    WAIT_OPC = 3'd2,
    EXEC     = 3'd3,
    SEND     = 3'd4,
    WAIT_TX  = 3'd5
  } state_t;

endpackage

// File: rtl/frame_timer.sv
// Idle-cycle counter between bytes of one frame.
// Saturates instead of wrapping; expired only while enabled.
module frame_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Collects op1/op2/opcode bytes from the UART, drives the ALU,
// and hands the result byte to the transmitter.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int BUS_LEN     = 8,
  parameter int OPCODE_LEN  = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [BUS_LEN-1:0]    i_rx_data,
  input  logic                  i_rx_done,
  input  logic [BUS_LEN-1:0]    i_result,
  input  logic                  i_tx_done,
  output logic [BUS_LEN-1:0]    o_ope1,
  output logic [BUS_LEN-1:0]    o_ope2,
  output logic [OPCODE_LEN-1:0] o_opcode,
  output logic [BUS_LEN-1:0]    o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_error
);

  state_t state_q, state_d;

  logic [BUS_LEN-1:0]    ope1_q, ope1_d;
  logic [BUS_LEN-1:0]    ope2_q, ope2_d;
  logic [OPCODE_LEN-1:0] opcode_q, opcode_d;
  logic [BUS_LEN-1:0]    tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  error_q, error_d;

  logic [OPCODE_LEN-1:0] op_w;
  logic                  hi_zero;
  logic                  op_valid;
  logic                  expired;
  logic                  timer_en;
  logic                  timer_clear;

  assign op_w    = i_rx_data[OPCODE_LEN-1:0];
  assign hi_zero = (i_rx_data >> OPCODE_LEN) == '0;

  // Bits above the opcode field must be zero for the byte to count.
  assign op_valid = hi_zero && (op_w inside {
    OPCODE_LEN'(ADD), OPCODE_LEN'(SUB), OPCODE_LEN'(AND),
    OPCODE_LEN'(OR),  OPCODE_LEN'(XOR), OPCODE_LEN'(SRA),
    OPCODE_LEN'(SRL), OPCODE_LEN'(NOR)
  });

  always_comb begin
    state_d    = state_q;
    ope1_d     = ope1_q;
    ope2_d     = ope2_q;
    opcode_d   = opcode_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    error_d    = 1'b0;
    unique case (state_q)
      WAIT_OP1: begin
        if (i_rx_done) begin
          ope1_d  = i_rx_data;
          state_d = WAIT_OP2;
        end
      end
      WAIT_OP2: begin
        if (i_rx_done) begin
          ope2_d  = i_rx_data;
          state_d = WAIT_OPC;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = WAIT_OP1;
        end
      end
      WAIT_OPC: begin
        if (i_rx_done) begin
          if (op_valid) begin
            opcode_d = op_w;
            state_d  = EXEC;
          end else begin
            error_d = 1'b1;
            state_d = WAIT_OP1;
          end
        end else if (expired) begin
          error_d = 1'b1;
          state_d = WAIT_OP1;
        end
      end
      EXEC: begin
        tx_data_d  = i_result;
        tx_start_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          state_d = WAIT_OP1;
        end
      end
      default: begin
        state_d = WAIT_OP1;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= WAIT_OP1;
      ope1_q     <= '0;
      ope2_q     <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ope1_q     <= ope1_d;
      ope2_q     <= ope2_d;
      opcode_q   <= opcode_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      error_q    <= error_d;
    end
  end

  assign timer_en    = (state_q == WAIT_OP2) || (state_q == WAIT_OPC);
  assign timer_clear = i_rx_done || (state_d != state_q);

  frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  assign o_ope1     = ope1_q;
  assign o_ope2     = ope2_q;
  assign o_opcode   = opcode_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_error    = error_q;
  assign o_busy     = (state_q != WAIT_OP1);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: frame-level model plus directed frames.
// An ALU function beside the DUT feeds i_result.
module tb_alu_seq_ctrl;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] result;
  logic       tx_done;
  logic [7:0] ope1, ope2, tx_data;
  logic [5:0] opcode;
  logic       tx_start, busy, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(
    .BUS_LEN     (8),
    .OPCODE_LEN  (6),
    .TIMEOUT_CYC (T)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_rx_data  (rx_data),
    .i_rx_done  (rx_done),
    .i_result   (result),
    .i_tx_done  (tx_done),
    .o_ope1     (ope1),
    .o_ope2     (ope2),
    .o_opcode   (opcode),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .o_busy     (busy),
    .o_error    (error)
  );

  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b,
                                       logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h03:   return sa >>> b;
      6'h02:   return a >> b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit op_ok(logic [7:0] b);
    return b inside {8'h20, 8'h22, 8'h24, 8'h25,
                     8'h26, 8'h03, 8'h02, 8'h27};
  endfunction

  always_comb result = alu_f(ope1, ope2, opcode);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: counts bytes collected and, once an opcode is
  // accepted at edge opc_edge, knows when the result and tx request appear.
  int         got, idle;
  longint     e, opc_edge;
  bit         active;
  logic [7:0] m_ope1, m_ope2, m_txd;
  logic [5:0] m_opc;
  bit         m_start, m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      got <= 0; idle <= 0; e <= 0; opc_edge <= 0; active <= 0;
      m_ope1 <= 0; m_ope2 <= 0; m_txd <= 0; m_opc <= 0;
      m_start <= 0; m_err <= 0;
    end else begin
      e <= e + 1;
      m_start <= 0;
      m_err <= 0;
      if (active) begin
        if (e == opc_edge + 1) begin
          m_txd <= alu_f(m_ope1, m_ope2, m_opc);
          m_start <= 1;
        end else if (e >= opc_edge + 3 && tx_done) begin
          active <= 0;
        end
      end else if (rx_done) begin
        idle <= 0;
        if (got == 0) begin
          m_ope1 <= rx_data; got <= 1;
        end else if (got == 1) begin
          m_ope2 <= rx_data; got <= 2;
        end else if (op_ok(rx_data)) begin
          m_opc <= rx_data[5:0]; active <= 1; opc_edge <= e; got <= 0;
        end else begin
          m_err <= 1; got <= 0;
        end
      end else if (got > 0) begin
        if (idle + 1 == T) begin
          m_err <= 1; got <= 0; idle <= 0;
        end else begin
          idle <= idle + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_ope1", ope1, m_ope1);
    chk("m_ope2", ope2, m_ope2);
    chk("m_opcode", opcode, m_opc);
    chk("m_tx_data", tx_data, m_txd);
    chk("m_tx_start", tx_start, m_start);
    chk("m_error", error, m_err);
    chk("m_busy", busy, active || got > 0);
  end

  task automatic send_byte(logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic finish_frame(logic [7:0] op, logic [7:0] exp);
    send_byte(op);
    chk("exec_no_start", tx_start, 0);
    @(negedge clk);
    chk("latency_start", tx_start, 1);
    chk("tx_data", tx_data, exp);
    @(negedge clk);
    chk("wait_tx_busy", busy, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("busy_after_done", busy, 0);
  endtask

  task automatic run_frame(logic [7:0] a, logic [7:0] b,
                           logic [7:0] op, logic [7:0] exp);
    send_byte(a);
    send_byte(b);
    finish_frame(op, exp);
  endtask

  task automatic chk_zero(string name);
    chk({name, "_ope1"}, ope1, 0);
    chk({name, "_ope2"}, ope2, 0);
    chk({name, "_opc"}, opcode, 0);
    chk({name, "_txd"}, tx_data, 0);
    chk({name, "_start"}, tx_start, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_err"}, error, 0);
  endtask

  initial begin
    rst = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    run_frame(8'h05, 8'h03, 8'h20, 8'h08);
    run_frame(8'h03, 8'h05, 8'h22, 8'hFE);
    run_frame(8'h80, 8'h02, 8'h03, 8'hE0);
    run_frame(8'h0F, 8'hF0, 8'h27, 8'h00);

    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h3F);
    chk("bad_op_err", error, 1);
    chk("bad_op_busy", busy, 0);
    chk("bad_op_opc", opcode, 6'h27);
    @(negedge clk);
    chk("bad_op_pulse", error, 0);
    chk("bad_op_nostart", tx_start, 0);
    run_frame(8'h01, 8'h02, 8'h20, 8'h03);

    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h60);
    chk("hi_bits_err", error, 1);
    @(negedge clk);

    send_byte(8'h11);
    repeat (T - 1) @(negedge clk);
    chk("pre_timeout_err", error, 0);
    chk("pre_timeout_busy", busy, 1);
    @(negedge clk);
    chk("timeout_err", error, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_ope1", ope1, 8'h11);
    @(negedge clk);
    chk("timeout_pulse", error, 0);

    send_byte(8'h22);
    repeat (T - 1) @(negedge clk);
    send_byte(8'h33);
    chk("race_err", error, 0);
    chk("race_busy", busy, 1);
    chk("race_ope2", ope2, 8'h33);
    finish_frame(8'h20, 8'h55);

    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    @(negedge clk);
    @(negedge clk);
    send_byte(8'h77);
    send_byte(8'h78);
    chk("ignore_ope1", ope1, 8'h05);
    chk("ignore_busy", busy, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("ignore_done_busy", busy, 0);

    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("rst_wait_tx");
    @(negedge clk);
    rst = 1'b0;
    run_frame(8'h04, 8'h04, 8'h26, 8'h00);

    send_byte(8'h09);
    send_byte(8'h0A);
    #2 rst = 1'b1;
    #1 chk_zero("rst_wait_opc");
    @(negedge clk);
    rst = 1'b0;
    run_frame(8'h04, 8'h04, 8'h26, 8'h00);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
